axil_data_mem: RTL and testbench
================================

Name: axil_data_mem

Overview:
- AXI4-Lite slave data memory; next generation of the core data memory.
- Parametrised data width and depth; byte-lane storage built from the existing single-port bram, one instance per byte.
- Fully compliant VALID/READY handshakes on all five channels, with real B-channel responses and read backpressure with data hold.
- Out-of-range addresses return SLVERR.
- Sits on the core's data-side AXI interconnect port.

Parameters:
- AXI_ADDR_WIDTH, 32: byte-address width of awaddr/araddr.
- DATA_WIDTH, 32: data bus width; legal values 32 or 64.
- WORD_ADDR_WIDTH, 14: log2 of memory depth in words.
- Derived (localparam, not overridable): STRB_WIDTH = DATA_WIDTH/8; OFFS = log2(STRB_WIDTH).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- awaddr  in  AXI_ADDR_WIDTH  write byte address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  STRB_WIDTH  byte enables
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response (00 OKAY, 10 SLVERR)
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  AXI_ADDR_WIDTH  read byte address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- Clock and reset are fixed: one clock aclk; aresetn asynchronous, active-low. All ports are grouped via axi_intf.slave at the instantiation boundary.

Behaviour:
- Reset values:
  - bvalid, rvalid = 0; bresp, rresp = 00; rdata = 0.
  - AW and W holding registers empty; awready = wready = 1.
  - arready = 1.
- Memory contents are not reset.
- Reset mid-operation drops all in-flight transactions. A memory write committed before reset assertion persists.
- Word index = addr[OFFS+WORD_ADDR_WIDTH-1:OFFS]. Address bits above that range nonzero means out of range. Low OFFS bits are ignored (aligned access).
- Write path:
  - AW and W are accepted independently.
  - awready = !aw_held; wready = !w_held.
  - A beat accepted while its partner is absent is stored in a one-entry holding register.
  - fire_w = (aw_held | awvalid&awready) & (w_held | wvalid&wready) & (!bvalid | bready).
  - On fire_w, in range: bram lane i is written iff wstrb[i], at that edge. Out of range: no lane written.
  - bvalid asserts the cycle after fire_w, with bresp = 00 (in range) or 10 (out of range). Holding registers clear.
  - bvalid stays high with bresp stable until bready. fire_w is blocked while bvalid & !bready.
  - Best-case throughput is 1 write/cycle (bready held high). Latency from AW+W handshake to bvalid is 1 cycle.
- Read path:
  - arready = !rvalid | rready.
  - AR handshake at edge N drives the bram address. At N+1, rvalid = 1, rdata = bram dout (or 0 if out of range), rresp = 00 or 10.
  - If rvalid & !rready: rdata is captured into a hold register and rdata/rresp stay stable until rready, even if a write to the same word occurs meanwhile.
  - Back-to-back reads sustain 1/cycle with rready high.
- Simultaneous read and write to the same word in one cycle: the read returns the pre-write data (read-first). Read and write ports are independent; the bram is true dual-port (write addr/read addr), or is written as read-first.
- Partial strobe (e.g. 0b0101) modifies only the enabled lanes. wstrb = 0 completes with OKAY and changes nothing.

Decomposition:
- Package axil_pkg:
  - resp_t enum (OKAY = 2'b00, SLVERR = 2'b10).
  - Default width constants.
  - Function clog2-based OFFS helper.
- Sub-module: the existing bram, instanced STRB_WIDTH times by generate, extended to separate read/write address ports.
- Write- and read-channel logic stays in axil_data_mem; no further hierarchy.

Test Plan:
- Write 0xDEADBEEF, wstrb 0xF, to 0x100; then read 0x100 -> bresp 00; rdata 0xDEADBEEF, rresp 00, rvalid 1 cycle after AR handshake.
- AW at cycle 0, W at cycle 3 (addr 0x104, data 0x11223344, wstrb 0b0101); then read -> bvalid at cycle 4; read returns 0x00220044 over prior 0.
- Hold bready = 0 for 5 cycles after a write, then issue a second write -> awready/wready drop once holds fill; second write not committed until bready; two bresp 00 in order.
- Read 0x200 (contains 0xA5A5A5A5) with rready = 0 for 4 cycles while writing 0x0 to 0x200 -> rdata holds 0xA5A5A5A5 until rready; next read returns 0x0.
- Write/read at byte address 1<<(WORD_ADDR_WIDTH+OFFS) -> bresp 10, no memory change (alias word 0 unchanged); rresp 10, rdata 0.
- Assert aresetn low while bvalid is pending and a read is outstanding -> bvalid = rvalid = 0 immediately (asynchronous); awready = wready = arready = 1 after release; committed data still readable.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite data memory.
//   resp_t               : AXI response codes driven on bresp/rresp
//   DEF_*                : default parameter values for axil_data_mem
//   offs_for(data_width) : number of byte-offset address bits for a bus width
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam int DEF_AXI_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_WORD_ADDR_WIDTH = 14;

  // Byte-offset bits within one data word (2 for 32-bit, 3 for 64-bit).
  function automatic int offs_for(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_data_mem_bram.sv
// Single byte-lane block RAM with independent write and read addresses.
// One instance per byte lane of the AXI data bus.
//   clk   : clock
//   we    : write enable for this lane
//   waddr : write word address
//   wdata : write byte
//   re    : read enable; dout updates on the edge where re is high
//   raddr : read word address
//   dout  : registered read data, held while re is low
// A write and a read of the same address on one edge return the old byte
// (read-first), since both use non-blocking updates of the same array.
// Contents are not reset.
module axil_data_mem_bram #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      dout <= mem[raddr];
    end
  end

endmodule

// File: rtl/axil_data_mem.sv
// AXI4-Lite slave data memory.
// Ports:
//   aclk, aresetn                    : clock, asynchronous active-low reset
//   awaddr/awvalid/awready           : write address channel
//   wdata/wstrb/wvalid/wready        : write data channel
//   bresp/bvalid/bready              : write response channel
//   araddr/arvalid/arready           : read address channel
//   rdata/rresp/rvalid/rready        : read data channel
// Storage is STRB_WIDTH byte-lane brams. Addresses with any bit set above
// the word index are out of range: writes are dropped, reads return zero,
// and both respond SLVERR. The low byte-offset bits are ignored.
module axil_data_mem
  import axil_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = DEF_AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int WORD_ADDR_WIDTH = DEF_WORD_ADDR_WIDTH
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFFS       = offs_for(DATA_WIDTH);
  localparam int HI         = OFFS + WORD_ADDR_WIDTH;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("axil_data_mem: DATA_WIDTH must be 32 or 64");
  end
  if (HI > AXI_ADDR_WIDTH) begin : g_bad_addr_width
    $error("axil_data_mem: memory larger than the AXI address space");
  end

  // ---------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------
  logic                      aw_held;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic                      w_held;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [STRB_WIDTH-1:0]     wstrb_q;

  logic                       aw_hs;
  logic                       w_hs;
  logic                       fire_w;
  logic [AXI_ADDR_WIDTH-1:0]  aw_addr_eff;
  logic [DATA_WIDTH-1:0]      wdata_eff;
  logic [STRB_WIDTH-1:0]      wstrb_eff;
  logic [WORD_ADDR_WIDTH-1:0] aw_idx;
  logic                       aw_oor;

  assign awready = !aw_held;
  assign wready  = !w_held;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  // A held beat takes priority over the live bus; the live bus is only
  // accepted while the matching holding register is empty anyway.
  assign aw_addr_eff = aw_held ? aw_addr_q : awaddr;
  assign wdata_eff   = w_held  ? wdata_q   : wdata;
  assign wstrb_eff   = w_held  ? wstrb_q   : wstrb;

  assign aw_idx = aw_addr_eff[HI-1:OFFS];
  assign aw_oor = (aw_addr_eff >> HI) != '0;

  // Gating with aresetn keeps a beat presented during reset out of the RAM.
  assign fire_w = aresetn
               && (aw_held || aw_hs)
               && (w_held || w_hs)
               && (!bvalid || bready);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
    end else begin
      if (fire_w) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_oor ? SLVERR : OKAY;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= awaddr;
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= wdata;
          wstrb_q <= wstrb;
        end
        if (bready) begin
          bvalid <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic                       ar_hs;
  logic [WORD_ADDR_WIDTH-1:0] ar_idx;
  logic                       ar_oor;
  logic [DATA_WIDTH-1:0]      dout_word;
  logic                       r_oor;
  logic                       r_held;
  logic [DATA_WIDTH-1:0]      rdata_hold;

  assign arready = !rvalid || rready;
  assign ar_hs   = arvalid && arready;
  assign ar_idx  = araddr[HI-1:OFFS];
  assign ar_oor  = (araddr >> HI) != '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid     <= 1'b0;
      rresp      <= OKAY;
      r_oor      <= 1'b0;
      r_held     <= 1'b0;
      rdata_hold <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rresp  <= ar_oor ? SLVERR : OKAY;
      r_oor  <= ar_oor;
      r_held <= 1'b0;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
      r_held <= 1'b0;
    end else if (rvalid && !r_held) begin
      // First stalled cycle: freeze the beat so rdata cannot move until
      // the master takes it.
      r_held     <= 1'b1;
      rdata_hold <= dout_word;
    end
  end

  // RAM output is registered on the AR edge, so the first cycle of a beat
  // is served straight from dout; later stalled cycles come from the hold.
  always_comb begin
    rdata = '0;
    if (rvalid && !r_oor) begin
      rdata = r_held ? rdata_hold : dout_word;
    end
  end

  // ---------------------------------------------------------------------
  // Byte-lane storage
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < STRB_WIDTH; i++) begin : g_lane
    axil_data_mem_bram #(
      .ADDR_WIDTH (WORD_ADDR_WIDTH),
      .DATA_WIDTH (8)
    ) u_bram (
      .clk   (aclk),
      .we    (fire_w && !aw_oor && wstrb_eff[i]),
      .waddr (aw_idx),
      .wdata (wdata_eff[8*i +: 8]),
      .re    (ar_hs),
      .raddr (ar_idx),
      .dout  (dout_word[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_axil_data_mem.sv
// Directed bench for axil_data_mem with default parameters
// (32-bit data, 14-bit word index, so byte address 0x10000 is out of range).
module tb_axil_data_mem;

  logic        aclk;
  logic        aresetn;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_cmp = 0;
  int n_err = 0;

  axil_data_mem dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_done, w_done, hs_aw, hs_w;
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      step();
      n++;
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
      if (hs_w)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_handshake", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!bvalid && n < 20) begin step(); n++; end
    check("wr_bvalid", bvalid, 1'b1);
    resp = bresp;
    step();
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1; n = 0;
    while (!arready && n < 20) begin step(); n++; end
    step();
    arvalid = 1'b0;
    check("rd_rvalid_latency", rvalid, 1'b1);
    d = rdata;
    resp = rresp;
    step();
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    step(); step();
    check("rst_bvalid",  bvalid,  1'b0);
    check("rst_rvalid",  rvalid,  1'b0);
    check("rst_bresp",   bresp,   2'b00);
    check("rst_rresp",   rresp,   2'b00);
    check("rst_rdata",   rdata,   32'h0);
    check("rst_awready", awready, 1'b1);
    check("rst_wready",  wready,  1'b1);
    check("rst_arready", arready, 1'b1);
    aresetn = 1'b1;
    step();

    // Full-word write then read back.
    axi_write(32'h100, 32'hDEADBEEF, 4'hF, resp);
    check("t1_bresp", resp, 2'b00);
    axi_read(32'h100, rd, resp);
    check("t1_rdata", rd, 32'hDEADBEEF);
    check("t1_rresp", resp, 2'b00);

    // AW at cycle 0, W at cycle 3, partial strobe.
    axi_write(32'h104, 32'h0, 4'hF, resp);
    awaddr = 32'h104; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
    step();
    awvalid = 1'b0;
    check("t2_awready_held", awready, 1'b0);
    check("t2_bvalid_c1", bvalid, 1'b0);
    step(); step();
    check("t2_bvalid_c3", bvalid, 1'b0);
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check("t2_bvalid_c4", bvalid, 1'b1);
    check("t2_bresp", bresp, 2'b00);
    check("t2_awready_free", awready, 1'b1);
    step();
    check("t2_bvalid_done", bvalid, 1'b0);
    axi_read(32'h104, rd, resp);
    check("t2_rdata", rd, 32'h00220044);

    // B backpressure: second write waits in the holding registers.
    axi_write(32'h10C, 32'h12345678, 4'hF, resp);
    bready = 1'b0;
    awaddr = 32'h108; wdata = 32'h0A0A0A0A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t3_bvalid_first", bvalid, 1'b1);
    awaddr = 32'h10C; wdata = 32'h0B0B0B0B; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t3_awready_full", awready, 1'b0);
    check("t3_wready_full", wready, 1'b0);
    check("t3_bvalid_stall", bvalid, 1'b1);
    axi_read(32'h10C, rd, resp);
    check("t3_not_committed", rd, 32'h12345678);
    step();
    check("t3_bresp_first", bresp, 2'b00);
    bready = 1'b1;
    step();
    check("t3_bvalid_second", bvalid, 1'b1);
    check("t3_bresp_second", bresp, 2'b00);
    check("t3_awready_free", awready, 1'b1);
    check("t3_wready_free", wready, 1'b1);
    step();
    check("t3_bvalid_done", bvalid, 1'b0);
    axi_read(32'h10C, rd, resp);
    check("t3_rdata_second", rd, 32'h0B0B0B0B);
    axi_read(32'h108, rd, resp);
    check("t3_rdata_first", rd, 32'h0A0A0A0A);

    // Read stalled by rready while the same word is overwritten.
    axi_write(32'h200, 32'hA5A5A5A5, 4'hF, resp);
    araddr = 32'h200; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    check("t4_rvalid", rvalid, 1'b1);
    check("t4_rdata_c0", rdata, 32'hA5A5A5A5);
    awaddr = 32'h200; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t4_write_done", bvalid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_rdata_hold", rdata, 32'hA5A5A5A5);
      check("t4_arready_stall", arready, 1'b0);
    end
    check("t4_rvalid_hold", rvalid, 1'b1);
    rready = 1'b1;
    step();
    check("t4_rvalid_done", rvalid, 1'b0);
    axi_read(32'h200, rd, resp);
    check("t4_rdata_new", rd, 32'h0);

    // Out-of-range address aliasing word 0.
    axi_write(32'h0, 32'h5A5A5A5A, 4'hF, resp);
    axi_write(32'h10000, 32'hFFFFFFFF, 4'hF, resp);
    check("t5_bresp_oor", resp, 2'b10);
    axi_read(32'h10000, rd, resp);
    check("t5_rresp_oor", resp, 2'b10);
    check("t5_rdata_oor", rd, 32'h0);
    axi_read(32'h0, rd, resp);
    check("t5_word0_intact", rd, 32'h5A5A5A5A);
    check("t5_word0_rresp", resp, 2'b00);

    // Zero strobe completes OKAY and changes nothing.
    axi_write(32'h100, 32'h0, 4'h0, resp);
    check("t6_bresp_nostrb", resp, 2'b00);
    axi_read(32'h100, rd, resp);
    check("t6_rdata_nostrb", rd, 32'hDEADBEEF);

    // Asynchronous reset with a pending response and an outstanding read.
    bready = 1'b0;
    awaddr = 32'h300; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h300; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    check("t7_bvalid_pending", bvalid, 1'b1);
    check("t7_rvalid_pending", rvalid, 1'b1);
    #1 aresetn = 1'b0;
    #1;
    check("t7_bvalid_async", bvalid, 1'b0);
    check("t7_rvalid_async", rvalid, 1'b0);
    step();
    aresetn = 1'b1;
    bready = 1'b1; rready = 1'b1;
    step();
    check("t7_awready", awready, 1'b1);
    check("t7_wready", wready, 1'b1);
    check("t7_arready", arready, 1'b1);
    axi_read(32'h300, rd, resp);
    check("t7_committed", rd, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
